pipe_stall_ctrl: RTL and testbench

Consumer side of the pipeline's hazard Stall signal. It owns the PC register, the IF/ID pipeline register and the control field of the ID/EX register. It applies stalls (freeze PC and IF/ID, inject an ID/EX bubble) and taken-branch redirects (load target, squash the fetched slot). It also keeps saturating stall/flush statistics and a stuck-stall watchdog. It sits between instruction fetch, the decoder and the hazard detection unit.

---
 rtl/pipe_stall_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/redirect consumer: owns PC, IF/ID and the ID/EX control field, applies
// hazard stalls and taken-branch squashes, and keeps stall/flush statistics.
module pipe_stall_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          CTRL_W     = 10,
  parameter bit          DELAY_SLOT = 1'b0,
  parameter int          MAX_STALL  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       if_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [31:0]       pc,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc4,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              flush,
  output logic [1:0]        state,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count,
  output logic              stall_err
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Handshake: stall is a level request from the hazard unit. While it is high
  // this block accepts nothing from fetch or decode; when it is low, fetch and
  // decode are consumed every cycle (there is no separate valid/ready pair).

  localparam logic [3:0]  MAX_RL   = 4'(MAX_STALL);
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;
  localparam logic [3:0]  RL_MAX   = 4'hF;

  state_t      state_q;
  logic [3:0]  run_len;
  logic [31:0] pc_plus4;
  logic        squash;

  assign pc_plus4   = pc + PC_STEP;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;
  assign state      = state_q;
  assign squash     = ~stall & branch_taken & ~DELAY_SLOT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      ifid_instr  <= 32'h0;
      ifid_pc4    <= 32'h0;
      idex_ctrl   <= '0;
      flush       <= 1'b0;
      state_q     <= ST_RUN;
      stall_count <= 16'h0;
      flush_count <= 16'h0;
      stall_err   <= 1'b0;
      run_len     <= 4'h0;
    end else if (stall) begin
      // Hold fetch state, push a bubble; any branch waits to re-resolve.
      idex_ctrl <= '0;
      flush     <= 1'b0;
      state_q   <= ST_STALL;
      if (stall_count != CNT_MAX) stall_count <= stall_count + 16'd1;
      if (run_len != RL_MAX) run_len <= run_len + 4'd1;
      // This edge brings the run length to MAX_STALL+1.
      if (run_len >= MAX_RL) stall_err <= 1'b1;
    end else begin
      run_len   <= 4'h0;
      idex_ctrl <= id_ctrl;
      if (branch_taken) begin
        pc <= branch_target;
        if (squash) begin
          ifid_instr <= 32'h0;
          ifid_pc4   <= 32'h0;
          flush      <= 1'b1;
          state_q    <= ST_FLUSH;
          if (flush_count != CNT_MAX) flush_count <= flush_count + 16'd1;
        end else begin
          ifid_instr <= if_instr;
          ifid_pc4   <= pc_plus4;
          flush      <= 1'b0;
          state_q    <= ST_RUN;
        end
      end else begin
        pc         <= pc_plus4;
        ifid_instr <= if_instr;
        ifid_pc4   <= pc_plus4;
        flush      <= 1'b0;
        state_q    <= ST_RUN;
      end
    end
  end

  // Internal consistency: flush and the FLUSH state always travel together.
  flush_state_a: assert property (@(posedge clk) disable iff (!rst_n)
    flush == (state_q == ST_FLUSH));

  stall_bubble_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_STALL) |-> (idex_ctrl == '0));

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (DELAY_SLOT=0, MAX_STALL=4).
module tb_pipe_stall_ctrl;

  localparam int CTRL_W = 10;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic [31:0]       if_instr;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       pc;
  logic [31:0]       ifid_instr;
  logic [31:0]       ifid_pc4;
  logic [CTRL_W-1:0] idex_ctrl;
  logic              pc_write;
  logic              ifid_write;
  logic              flush;
  logic [1:0]        state;
  logic [15:0]       stall_count;
  logic [15:0]       flush_count;
  logic              stall_err;

  int checks;
  int errors;

  pipe_stall_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .CTRL_W    (CTRL_W),
    .DELAY_SLOT(1'b0),
    .MAX_STALL (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_instr     (if_instr),
    .id_ctrl      (id_ctrl),
    .pc           (pc),
    .ifid_instr   (ifid_instr),
    .ifid_pc4     (ifid_pc4),
    .idex_ctrl    (idex_ctrl),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .flush        (flush),
    .state        (state),
    .stall_count  (stall_count),
    .flush_count  (flush_count),
    .stall_err    (stall_err)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: apply inputs, take one edge, sample 1ns after it.
  task automatic step(input logic s, input logic b, input logic [31:0] tgt,
                      input logic [31:0] ins, input logic [CTRL_W-1:0] ctl);
    stall         = s;
    branch_taken  = b;
    branch_target = tgt;
    if_instr      = ins;
    id_ctrl       = ctl;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [31:0] ins, input logic [CTRL_W-1:0] ctl);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, ins, ctl);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    if_instr = 32'h0;
    id_ctrl = '0;
    #12;
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_ifid_instr", ifid_instr, 32'h0);
    check_eq("rst_ifid_pc4", ifid_pc4, 32'h0);
    check_eq("rst_idex", 32'(idex_ctrl), 32'h0);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_flush", 32'(flush), 32'd0);
    check_eq("rst_err", 32'(stall_err), 32'd0);
    check_eq("rst_pc_write", 32'(pc_write), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal advance
    step(1'b0, 1'b0, 32'h0, 32'h2000_0001, 10'h155);
    check_eq("adv1_pc", pc, 32'h4);
    run(2, 32'h2000_0001, 10'h155);
    check_eq("adv3_pc", pc, 32'hC);
    check_eq("adv3_ifid_pc4", ifid_pc4, 32'hC);
    check_eq("adv3_ifid_instr", ifid_instr, 32'h2000_0001);
    check_eq("adv3_idex", 32'(idex_ctrl), 32'h155);
    check_eq("adv3_state", 32'(state), 32'd0);
    run(1, 32'h2000_0001, 10'h155);
    check_eq("adv4_pc", pc, 32'h10);

    // Two-cycle stall at pc=0x10
    stall = 1'b1;
    #1;
    check_eq("stall_pc_write", 32'(pc_write), 32'd0);
    check_eq("stall_ifid_write", 32'(ifid_write), 32'd0);
    step(1'b1, 1'b0, 32'h0, 32'h1111_1111, 10'h3FF);
    check_eq("stall1_pc", pc, 32'h10);
    check_eq("stall1_idex", 32'(idex_ctrl), 32'h0);
    check_eq("stall1_state", 32'(state), 32'd1);
    step(1'b1, 1'b0, 32'h0, 32'h1111_1111, 10'h3FF);
    check_eq("stall2_pc", pc, 32'h10);
    check_eq("stall2_ifid_instr", ifid_instr, 32'h2000_0001);
    check_eq("stall2_ifid_pc4", ifid_pc4, 32'h10);
    check_eq("stall2_idex", 32'(idex_ctrl), 32'h0);
    check_eq("stall2_count", 32'(stall_count), 32'd2);
    step(1'b0, 1'b0, 32'h0, 32'h1111_1111, 10'h3FF);
    check_eq("unstall_pc", pc, 32'h14);
    check_eq("unstall_idex", 32'(idex_ctrl), 32'h3FF);
    check_eq("unstall_ifid_instr", ifid_instr, 32'h1111_1111);
    check_eq("unstall_state", 32'(state), 32'd0);
    check_eq("unstall_pc_write", 32'(pc_write), 32'd1);

    // Squashing branch at pc=0x20
    run(3, 32'h0000_0013, 10'h0AA);
    check_eq("pre_br_pc", pc, 32'h20);
    step(1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, 10'h0F0);
    check_eq("br_pc", pc, 32'h400);
    check_eq("br_ifid_instr", ifid_instr, 32'h0);
    check_eq("br_ifid_pc4", ifid_pc4, 32'h0);
    check_eq("br_flush", 32'(flush), 32'd1);
    check_eq("br_state", 32'(state), 32'd2);
    check_eq("br_flush_count", 32'(flush_count), 32'd1);
    check_eq("br_idex", 32'(idex_ctrl), 32'h0F0);
    step(1'b0, 1'b0, 32'h0, 32'h0000_0033, 10'h001);
    check_eq("post_br_pc", pc, 32'h404);
    check_eq("post_br_flush", 32'(flush), 32'd0);
    check_eq("post_br_state", 32'(state), 32'd0);
    check_eq("post_br_ifid_pc4", ifid_pc4, 32'h404);

    // Back-to-back taken branches keep flush high
    step(1'b0, 1'b1, 32'h800, 32'h0, 10'h0);
    check_eq("b2b1_flush", 32'(flush), 32'd1);
    step(1'b0, 1'b1, 32'h30, 32'h0, 10'h0);
    check_eq("b2b2_flush", 32'(flush), 32'd1);
    check_eq("b2b2_pc", pc, 32'h30);
    check_eq("b2b2_flush_count", 32'(flush_count), 32'd3);

    // Stall beats branch at pc=0x30
    step(1'b1, 1'b1, 32'h600, 32'h0, 10'h2AA);
    check_eq("sb_pc", pc, 32'h30);
    check_eq("sb_idex", 32'(idex_ctrl), 32'h0);
    check_eq("sb_flush", 32'(flush), 32'd0);
    check_eq("sb_state", 32'(state), 32'd1);
    check_eq("sb_flush_count", 32'(flush_count), 32'd3);
    step(1'b0, 1'b1, 32'h600, 32'h0, 10'h2AA);
    check_eq("sb_rel_pc", pc, 32'h600);
    check_eq("sb_rel_flush", 32'(flush), 32'd1);
    check_eq("sb_rel_count", 32'(stall_count), 32'd3);

    // Watchdog: 4 stalled cycles is tolerated
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 32'h0, 10'h0);
    check_eq("wd4_err", 32'(stall_err), 32'd0);
    check_eq("wd4_count", 32'(stall_count), 32'd7);
    step(1'b0, 1'b0, 32'h0, 32'h0, 10'h0);
    check_eq("wd4_rel_err", 32'(stall_err), 32'd0);
    // 5 stalled cycles trips it on the 5th edge
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 32'h0, 10'h0);
    check_eq("wd5_pre_err", 32'(stall_err), 32'd0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 10'h0);
    check_eq("wd5_err", 32'(stall_err), 32'd1);
    check_eq("wd5_count", 32'(stall_count), 32'd12);
    step(1'b0, 1'b0, 32'h0, 32'h0, 10'h0);
    run(2, 32'h0, 10'h0);
    check_eq("wd5_sticky", 32'(stall_err), 32'd1);

    // PC wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 10'h0);
    check_eq("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 32'h0000_0077, 10'h0);
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("wrap_ifid_pc4", ifid_pc4, 32'h0);

    // Asynchronous reset mid-stall at pc=0x50
    step(1'b0, 1'b1, 32'h50, 32'h0, 10'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 10'h1C3);
    check_eq("ar_pre_pc", pc, 32'h50);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_pc", pc, 32'h0);
    check_eq("ar_state", 32'(state), 32'd0);
    check_eq("ar_stall_count", 32'(stall_count), 32'd0);
    check_eq("ar_flush_count", 32'(flush_count), 32'd0);
    check_eq("ar_err", 32'(stall_err), 32'd0);
    check_eq("ar_ifid_pc4", ifid_pc4, 32'h0);
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("ar_rel_pc", pc, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 10'h0);
    check_eq("ar_first_pc", pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
